// File: rtl/fifo_frame_reader_pkg.sv
// Shared types for the packet FIFO frame reader: framing states and the
// beat record carried through the output buffer.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int LEN_WIDTH_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_FRAME = 2'd1,
        DROP     = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH_DEF-1:0] data;
        logic                      sof;
        logic                      eof;
        logic                      err;
        logic [LEN_WIDTH_DEF-1:0]  len;
    } beat_t;

endpackage

// File: rtl/fifo_frame_reader_if.sv
// Bus bundles for the frame reader: the FIFO read port it drains and the
// valid/ready byte stream it presents downstream.
interface fifo_rd_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_sof;
    logic                  fifo_eof;

    // master is the reader issuing strobes, slave is the FIFO
    modport master (input fifo_empty, output fifo_rd_en, input fifo_dout, input fifo_sof, input fifo_eof);
    modport slave  (output fifo_empty, input fifo_rd_en, output fifo_dout, output fifo_sof, output fifo_eof);
endinterface

interface frame_stream_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sof;
    logic                  out_eof;
    logic                  out_err;
    logic [LEN_WIDTH-1:0]  out_len;

    modport master (output out_valid, input out_ready, output out_data, output out_sof,
                    output out_eof, output out_err, output out_len);
    modport slave  (input out_valid, output out_ready, input out_data, input out_sof,
                    input out_eof, input out_err, input out_len);
endinterface

// File: rtl/fifo_frame_reader_skid_buf.sv
// Two-entry FIFO-ordered beat buffer; the writer guarantees there is always
// room, so there is no input-side ready.
module frame_skid_buf
    import fifo_pkg::*;
#(
    parameter type beat_type = fifo_pkg::beat_t
) (
    input  logic     clk,
    input  logic     srst,
    input  logic     in_valid,
    input  beat_type in_beat,
    output logic     out_valid,
    input  logic     out_ready,
    output beat_type out_beat,
    output logic [1:0] count
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       pop;

    assign pop       = out_valid && out_ready;
    assign out_valid = (count_reg != 2'd0);
    assign count     = count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            beat_type entry_reg;
            always_ff @(posedge clk) begin
                if (srst) begin
                    entry_reg <= '0;
                end else if (in_valid && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= in_beat;
                end
            end
        end
    endgenerate

    assign out_beat = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (in_valid) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, in_valid} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains sof/eof-tagged bytes from the packet FIFO, checks framing and
// length, and presents frames on a backpressured byte stream.
module fifo_frame_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int LEN_WIDTH     = LEN_WIDTH_DEF,
    parameter int MAX_FRAME_LEN = 1500
) (
    input  logic                 rd_clk,
    input  logic                 reset,
    fifo_rd_if.master            fifo,
    frame_stream_if.master       stream,
    output logic [LEN_WIDTH-1:0] stat_drop_cnt
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sof;
        logic                  eof;
        logic                  err;
        logic [LEN_WIDTH-1:0]  len;
    } frame_beat_t;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_FRAME_LEN);

    state_t               state_reg, state_next;
    logic [LEN_WIDTH-1:0] len_reg, len_next, len_inc;
    logic [LEN_WIDTH-1:0] drop_cnt_reg, drop_cnt_next;
    logic                 inflight_reg;
    logic                 emit;
    logic                 drop_inc;
    frame_beat_t          beat;
    frame_beat_t          head;
    logic                 buf_valid;
    logic [1:0]           buf_count;
    logic                 pop;
    logic [1:0]           occupancy;

    // The beat leaving this cycle frees its slot before the new read lands,
    // which is what sustains one byte per cycle.
    assign pop             = buf_valid && stream.out_ready;
    assign occupancy       = buf_count + {1'b0, inflight_reg} - {1'b0, pop};
    assign fifo.fifo_rd_en = !reset && !fifo.fifo_empty && (occupancy < 2'd2);
    assign len_inc         = len_reg + LEN_WIDTH'(1);

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            len_reg      <= '0;
            drop_cnt_reg <= '0;
            inflight_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            drop_cnt_reg <= drop_cnt_next;
            inflight_reg <= fifo.fifo_rd_en;
        end
    end

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        emit       = 1'b0;
        drop_inc   = 1'b0;
        beat       = '0;
        beat.data  = fifo.fifo_dout;
        if (inflight_reg) begin
            if (fifo.fifo_sof) begin
                // A sof inside a frame means the previous frame lost its tail.
                emit     = 1'b1;
                beat.sof = 1'b1;
                len_next = LEN_WIDTH'(1);
                if (state_reg == IN_FRAME) begin
                    beat.err = 1'b1;
                    drop_inc = 1'b1;
                end
                if (fifo.fifo_eof) begin
                    beat.eof   = 1'b1;
                    beat.len   = LEN_WIDTH'(1);
                    state_next = IDLE;
                end else begin
                    state_next = IN_FRAME;
                end
            end else if (state_reg == IN_FRAME) begin
                emit     = 1'b1;
                len_next = len_inc;
                if (fifo.fifo_eof) begin
                    beat.eof   = 1'b1;
                    beat.len   = len_inc;
                    state_next = IDLE;
                end else if (len_inc == MAX_LEN) begin
                    beat.eof   = 1'b1;
                    beat.err   = 1'b1;
                    beat.len   = len_inc;
                    drop_inc   = 1'b1;
                    state_next = DROP;
                end
            end else begin
                // Orphan bytes are counted once per run, on entry from IDLE.
                drop_inc   = (state_reg == IDLE);
                state_next = fifo.fifo_eof ? IDLE : DROP;
            end
        end
    end

    assign drop_cnt_next = (drop_inc && (drop_cnt_reg != '1)) ? drop_cnt_reg + LEN_WIDTH'(1)
                                                              : drop_cnt_reg;

    frame_skid_buf #(
        .beat_type (frame_beat_t)
    ) u_skid_buf (
        .clk       (rd_clk),
        .srst      (reset),
        .in_valid  (emit),
        .in_beat   (beat),
        .out_valid (buf_valid),
        .out_ready (stream.out_ready),
        .out_beat  (head),
        .count     (buf_count)
    );

    assign stream.out_valid = buf_valid;
    assign stream.out_data  = head.data;
    assign stream.out_sof   = head.sof;
    assign stream.out_eof   = head.eof;
    assign stream.out_err   = head.err;
    assign stream.out_len   = head.len;
    assign stat_drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Randomized bench for fifo_frame_reader: a queue-based FIFO and a byte-level
// framing reference model predict every output beat and the drop count.
module tb_fifo_frame_reader;

    localparam int DW  = 8;
    localparam int LW  = 16;
    localparam int MAX = 4;

    logic          rd_clk;
    logic          reset;
    logic [LW-1:0] stat_drop_cnt;

    fifo_rd_if #(.DATA_WIDTH(DW)) fifo_bus ();
    frame_stream_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) out_bus ();

    fifo_frame_reader #(
        .DATA_WIDTH    (DW),
        .LEN_WIDTH     (LW),
        .MAX_FRAME_LEN (MAX)
    ) dut (
        .rd_clk        (rd_clk),
        .reset         (reset),
        .fifo          (fifo_bus),
        .stream        (out_bus),
        .stat_drop_cnt (stat_drop_cnt)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    int n_checks = 0;
    int n_errors = 0;

    // FIFO contents {sof, eof, data}; expected beats {data, sof, eof, err, len}
    logic [DW+1:0]      fifo_q[$];
    logic [DW+LW+2:0]   exp_q[$];
    logic               pending;
    logic [DW+1:0]      pending_byte;
    int                 exp_drops;
    bit                 in_frame;
    bit                 dropping;
    int                 cur_len;
    int                 accepted;
    bit                 zero_check;
    bit                 ready_rand, stall_rand, hold_low, stall_cur;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void expect_beat(logic [DW-1:0] d, bit sof, bit eof, bit err, int len);
        exp_q.push_back({d, sof, eof, err, LW'(len)});
    endfunction

    function automatic void count_drop();
        if (exp_drops < (1 << LW) - 1) exp_drops++;
    endfunction

    // Framing rules applied to one byte as it is delivered by the FIFO.
    function automatic void model_byte(logic [DW+1:0] b);
        bit sof = b[DW+1];
        bit eof = b[DW];
        logic [DW-1:0] d = b[DW-1:0];
        if (sof) begin
            if (in_frame) count_drop();
            cur_len = 1;
            expect_beat(d, 1'b1, eof, in_frame, eof ? 1 : 0);
            in_frame = !eof;
            dropping = 1'b0;
        end else if (in_frame) begin
            cur_len++;
            if (eof) begin
                expect_beat(d, 1'b0, 1'b1, 1'b0, cur_len);
                in_frame = 1'b0;
            end else if (cur_len == MAX) begin
                expect_beat(d, 1'b0, 1'b1, 1'b1, MAX);
                count_drop();
                in_frame = 1'b0;
                dropping = 1'b1;
            end else begin
                expect_beat(d, 1'b0, 1'b0, 1'b0, 0);
            end
        end else begin
            if (!dropping) count_drop();
            dropping = !eof;
        end
    endfunction

    task automatic drive_inputs();
        stall_cur = stall_rand && ($urandom_range(0, 4) == 0);
        fifo_bus.fifo_empty = stall_cur || (fifo_q.size() == 0);
        if (hold_low) out_bus.out_ready = 1'b0;
        else if (ready_rand) out_bus.out_ready = ($urandom_range(0, 9) < 7);
        else out_bus.out_ready = 1'b1;
    endtask

    task automatic push_byte(input logic [DW-1:0] d, input bit sof, input bit eof);
        fifo_q.push_back({sof, eof, d});
        fifo_bus.fifo_empty = stall_cur || (fifo_q.size() == 0);
    endtask

    // One clock: check outputs mid-cycle, then advance the FIFO and model.
    task automatic cycle();
        logic rd, acc, rst;
        @(negedge rd_clk);
        if (zero_check) begin
            check("reset_outputs", {out_bus.out_valid, out_bus.out_data, out_bus.out_sof, out_bus.out_eof,
                                    out_bus.out_err, out_bus.out_len, stat_drop_cnt}, 64'd0);
            zero_check = 1'b0;
        end
        check("out_valid", out_bus.out_valid, exp_q.size() != 0);
        if (out_bus.out_valid && exp_q.size() != 0)
            check("beat", {out_bus.out_data, out_bus.out_sof, out_bus.out_eof, out_bus.out_err, out_bus.out_len},
                  exp_q[0]);
        check("drop_cnt", stat_drop_cnt, exp_drops);
        check("occupancy_le2", (exp_q.size() + int'(pending)) <= 2, 1'b1);
        check("rd_when_empty", fifo_bus.fifo_rd_en && fifo_bus.fifo_empty, 1'b0);
        if (reset) check("rd_in_reset", fifo_bus.fifo_rd_en, 1'b0);
        rd  = fifo_bus.fifo_rd_en && !fifo_bus.fifo_empty;
        acc = out_bus.out_valid && out_bus.out_ready;
        rst = reset;
        if (acc && !rst) begin
            accepted++;
            $display("beat data=%02h sof=%0b eof=%0b err=%0b len=%0d drops=%0d", out_bus.out_data,
                     out_bus.out_sof, out_bus.out_eof, out_bus.out_err, out_bus.out_len, stat_drop_cnt);
        end
        @(posedge rd_clk);
        #1;
        if (rst) begin
            exp_q.delete();
            pending   = 1'b0;
            in_frame  = 1'b0;
            dropping  = 1'b0;
            cur_len   = 0;
            exp_drops = 0;
        end else begin
            if (acc && exp_q.size() != 0) void'(exp_q.pop_front());
            if (pending) model_byte(pending_byte);
            pending = rd;
            if (rd && fifo_q.size() != 0) begin
                pending_byte = fifo_q.pop_front();
                fifo_bus.fifo_sof  = pending_byte[DW+1];
                fifo_bus.fifo_eof  = pending_byte[DW];
                fifo_bus.fifo_dout = pending_byte[DW-1:0];
            end
        end
        drive_inputs();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        zero_check = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((fifo_q.size() != 0 || pending || exp_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_timeout", (fifo_q.size() != 0 || pending || exp_q.size() != 0), 1'b0);
    endtask

    task automatic wait_accepted(input int target, input int budget);
        int n = 0;
        while (accepted < target && n < budget) begin
            cycle();
            n++;
        end
        check("accept_timeout", accepted >= target, 1'b1);
    endtask

    task automatic push_random_frame();
        int kind = $urandom_range(0, 9);
        int len;
        if (kind == 0) begin
            len = $urandom_range(1, 3);
            for (int i = 0; i < len; i++)
                push_byte(DW'($urandom), 1'b0, (i == len - 1) && ($urandom_range(0, 1) == 1));
        end else if (kind == 1) begin
            len = $urandom_range(1, 3);
            for (int i = 0; i < len; i++) push_byte(DW'($urandom), i == 0, 1'b0);
        end else begin
            len = $urandom_range(1, MAX + 2);
            for (int i = 0; i < len; i++) push_byte(DW'($urandom), i == 0, i == len - 1);
        end
    endtask

    initial begin
        int cycles, rst_at, base;
        reset = 1'b1;
        out_bus.out_ready = 1'b1;
        fifo_bus.fifo_empty = 1'b1;
        fifo_bus.fifo_dout = '0;
        fifo_bus.fifo_sof = 1'b0;
        fifo_bus.fifo_eof = 1'b0;
        pending = 1'b0;
        pending_byte = '0;
        exp_drops = 0;
        in_frame = 1'b0;
        dropping = 1'b0;
        cur_len = 0;
        accepted = 0;
        ready_rand = 1'b0;
        stall_rand = 1'b0;
        hold_low = 1'b0;
        stall_cur = 1'b0;
        repeat (3) @(posedge rd_clk);
        #1;
        reset = 1'b0;
        zero_check = 1'b1;

        // Three-byte frame at full rate
        push_byte(8'hAA, 1'b1, 1'b0);
        push_byte(8'hBB, 1'b0, 1'b0);
        push_byte(8'hCC, 1'b0, 1'b1);
        drain(50);

        // Eight-byte frame (truncated at MAX) with a five-cycle stall after byte 2
        base = accepted;
        for (int i = 0; i < 8; i++) push_byte(DW'(8'h40 + i), i == 0, i == 7);
        wait_accepted(base + 2, 50);
        hold_low = 1'b1;
        drive_inputs();
        repeat (5) cycle();
        hold_low = 1'b0;
        drive_inputs();
        drain(50);

        // Orphan bytes followed by a single-byte frame
        push_byte(8'h11, 1'b0, 1'b0);
        push_byte(8'h22, 1'b0, 1'b1);
        push_byte(8'h33, 1'b1, 1'b1);
        drain(50);

        // Frame restarted by an unexpected sof
        push_byte(8'h01, 1'b1, 1'b0);
        push_byte(8'h02, 1'b0, 1'b0);
        push_byte(8'h03, 1'b1, 1'b0);
        push_byte(8'h04, 1'b0, 1'b1);
        drain(50);

        // Reset after byte 2 of a five-byte frame, then a clean frame
        base = accepted;
        for (int i = 0; i < 5; i++) push_byte(DW'(8'h50 + i), i == 0, i == 4);
        wait_accepted(base + 2, 50);
        pulse_reset();
        for (int i = 0; i < 3; i++) push_byte(DW'(8'h60 + i), i == 0, i == 2);
        drain(50);

        // Random traffic with backpressure, FIFO stalls and occasional resets
        ready_rand = 1'b1;
        stall_rand = 1'b1;
        for (int it = 0; it < 60; it++) begin
            int nf = $urandom_range(1, 4);
            for (int f = 0; f < nf; f++) push_random_frame();
            cycles = $urandom_range(10, 40);
            rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, cycles - 1) : -1;
            for (int c = 0; c < cycles; c++) begin
                if (c == rst_at) pulse_reset();
                else cycle();
            end
        end
        drain(3000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
